// File: rtl/alu_seq_n_if.sv
// Operand/result bundle between the ID/EX operand registers and the sequential ALU.
// The stall unit only needs busy from this bundle.
interface alu_seq_n_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       FS;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] T;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Y_hi;
  logic [WIDTH-1:0] Y_lo;
  logic             C;
  logic             V;
  logic             N;
  logic             Z;
  logic             DZ;

  modport master (
    output start, FS, S, T,
    input  busy, done, Y_hi, Y_lo, C, V, N, Z, DZ
  );

  modport slave (
    input  start, FS, S, T,
    output busy, done, Y_hi, Y_lo, C, V, N, Z, DZ
  );
endinterface

// File: rtl/alu_seq_n.sv
// Sequential ALU: single-cycle logic/arithmetic plus iterative signed MUL/DIV
// on one shared shift/add datapath, with start/busy/done handshake and registered results.
module alu_seq_n #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_seq_n_if.slave bus
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam logic [4:0] FS_PASS_S = 5'h00;
  localparam logic [4:0] FS_PASS_T = 5'h01;
  localparam logic [4:0] FS_ADD    = 5'h02;
  localparam logic [4:0] FS_ADDU   = 5'h03;
  localparam logic [4:0] FS_SUB    = 5'h04;
  localparam logic [4:0] FS_SUBU   = 5'h05;
  localparam logic [4:0] FS_SLT    = 5'h06;
  localparam logic [4:0] FS_SLTU   = 5'h07;
  localparam logic [4:0] FS_AND    = 5'h08;
  localparam logic [4:0] FS_OR     = 5'h09;
  localparam logic [4:0] FS_XOR    = 5'h0A;
  localparam logic [4:0] FS_NOR    = 5'h0B;
  localparam logic [4:0] FS_SLL    = 5'h0C;
  localparam logic [4:0] FS_SRL    = 5'h0D;
  localparam logic [4:0] FS_SRA    = 5'h0E;
  localparam logic [4:0] FS_INC    = 5'h0F;
  localparam logic [4:0] FS_DEC    = 5'h10;
  localparam logic [4:0] FS_MUL    = 5'h1E;
  localparam logic [4:0] FS_DIV    = 5'h1F;

  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]    CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]    CNT_INIT = CNTW'(WIDTH - 1);

  logic [1:0]       state_r;
  logic             busy_r, done_r, c_r, v_r, n_r, z_r, dz_r;
  logic [WIDTH-1:0] y_hi_r, y_lo_r;
  logic             is_div_r;
  logic [WIDTH-1:0] op_s_r, op_t_r, mag_r, hi_r, lo_r;
  logic [CNTW-1:0]  count_r;

  logic [WIDTH-1:0] add_b_s;
  logic             add_cin_s;
  logic [WIDTH:0]   add_sum_s;
  logic             add_v_s;
  logic [WIDTH-1:0] sc_lo_s;
  logic             sc_c_s, sc_v_s;
  logic             is_iter_s;

  logic [WIDTH-1:0] abs_s_s, abs_t_s;
  logic [WIDTH-1:0] step_hi_in_s, step_lo_in_s, step_m_s;
  logic [WIDTH:0]   dp_a_s, dp_b_s;
  logic             dp_cin_s;
  logic [WIDTH+1:0] dp_sum_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s;

  logic             res_neg_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] fix_hi_s, fix_lo_s;
  logic             fix_v_s, fix_n_s, fix_dz_s;

  // Single-cycle operations: one adder serves ADD/SUB/INC/DEC, then the result mux.
  always_comb begin
    add_b_s   = bus.T;
    add_cin_s = 1'b0;
    case (bus.FS)
      FS_SUB, FS_SUBU: begin add_b_s = ~bus.T; add_cin_s = 1'b1; end
      FS_INC:          begin add_b_s = ONE_W;  add_cin_s = 1'b0; end
      FS_DEC:          begin add_b_s = ~ONE_W; add_cin_s = 1'b1; end
      default:         begin add_b_s = bus.T;  add_cin_s = 1'b0; end
    endcase
    add_sum_s = {1'b0, bus.S} + {1'b0, add_b_s} + {ZERO_W, add_cin_s};
    // Subtraction is S + ~T + 1, so overflow uses the sign of the operand actually added.
    add_v_s   = (bus.S[WIDTH-1] == add_b_s[WIDTH-1]) && (add_sum_s[WIDTH-1] != bus.S[WIDTH-1]);

    sc_lo_s = ZERO_W;
    sc_c_s  = 1'b0;
    sc_v_s  = 1'b0;
    case (bus.FS)
      FS_PASS_S: sc_lo_s = bus.S;
      FS_PASS_T: sc_lo_s = bus.T;
      FS_ADD, FS_SUB, FS_INC, FS_DEC: begin
        sc_lo_s = add_sum_s[WIDTH-1:0];
        sc_c_s  = add_sum_s[WIDTH];
        sc_v_s  = add_v_s;
      end
      FS_ADDU, FS_SUBU: begin
        sc_lo_s = add_sum_s[WIDTH-1:0];
        sc_c_s  = add_sum_s[WIDTH];
      end
      FS_SLT:  sc_lo_s = {{(WIDTH-1){1'b0}}, ($signed(bus.S) < $signed(bus.T))};
      FS_SLTU: sc_lo_s = {{(WIDTH-1){1'b0}}, (bus.S < bus.T)};
      FS_AND:  sc_lo_s = bus.S & bus.T;
      FS_OR:   sc_lo_s = bus.S | bus.T;
      FS_XOR:  sc_lo_s = bus.S ^ bus.T;
      FS_NOR:  sc_lo_s = ~(bus.S | bus.T);
      FS_SLL:  sc_lo_s = bus.S << bus.T[SHW-1:0];
      FS_SRL:  sc_lo_s = bus.S >> bus.T[SHW-1:0];
      FS_SRA:  sc_lo_s = $signed(bus.S) >>> bus.T[SHW-1:0];
      default: sc_lo_s = ZERO_W;
    endcase

    is_iter_s = (bus.FS == FS_MUL) || (bus.FS == FS_DIV);
  end

  // Shared MUL/DIV step; LOAD feeds fresh magnitudes so it performs the first step itself.
  always_comb begin
    abs_s_s = op_s_r[WIDTH-1] ? (~op_s_r + ONE_W) : op_s_r;
    abs_t_s = op_t_r[WIDTH-1] ? (~op_t_r + ONE_W) : op_t_r;

    if (state_r == ST_LOAD) begin
      step_hi_in_s = ZERO_W;
      step_lo_in_s = is_div_r ? abs_s_s : abs_t_s;
      step_m_s     = is_div_r ? abs_t_s : abs_s_s;
    end else begin
      step_hi_in_s = hi_r;
      step_lo_in_s = lo_r;
      step_m_s     = mag_r;
    end

    if (is_div_r) begin
      dp_a_s   = {step_hi_in_s, step_lo_in_s[WIDTH-1]};
      dp_b_s   = ~{1'b0, step_m_s};
      dp_cin_s = 1'b1;
    end else begin
      dp_a_s   = {1'b0, step_hi_in_s};
      dp_b_s   = step_lo_in_s[0] ? {1'b0, step_m_s} : {1'b0, ZERO_W};
      dp_cin_s = 1'b0;
    end
    dp_sum_s = {1'b0, dp_a_s} + {1'b0, dp_b_s} + {1'b0, ZERO_W, dp_cin_s};

    // For DIV the top carry is the no-borrow bit, i.e. the next quotient bit.
    if (is_div_r) begin
      step_hi_s = dp_sum_s[WIDTH+1] ? dp_sum_s[WIDTH-1:0] : dp_a_s[WIDTH-1:0];
      step_lo_s = {step_lo_in_s[WIDTH-2:0], dp_sum_s[WIDTH+1]};
    end else begin
      step_hi_s = dp_sum_s[WIDTH:1];
      step_lo_s = {dp_sum_s[0], step_lo_in_s[WIDTH-1:1]};
    end
  end

  // Sign fix-up and special cases for the MUL/DIV result.
  always_comb begin
    res_neg_s = op_s_r[WIDTH-1] ^ op_t_r[WIDTH-1];
    prod_s    = res_neg_s ? (~{hi_r, lo_r} + ONE_2W) : {hi_r, lo_r};
    fix_v_s   = 1'b0;
    fix_dz_s  = 1'b0;
    if (!is_div_r) begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end else if (op_t_r == ZERO_W) begin
      fix_hi_s = op_s_r;
      fix_lo_s = ONES_W;
      fix_dz_s = 1'b1;
    end else begin
      fix_hi_s = op_s_r[WIDTH-1] ? (~hi_r + ONE_W) : hi_r;
      fix_lo_s = res_neg_s ? (~lo_r + ONE_W) : lo_r;
      fix_v_s  = (op_s_r == MIN_W) && (op_t_r == ONES_W);
    end
    fix_n_s = is_div_r ? fix_lo_s[WIDTH-1] : fix_hi_s[WIDTH-1];
  end

  // Control FSM, iteration registers and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      y_hi_r   <= ZERO_W;
      y_lo_r   <= ZERO_W;
      c_r      <= 1'b0;
      v_r      <= 1'b0;
      n_r      <= 1'b0;
      z_r      <= 1'b0;
      dz_r     <= 1'b0;
      is_div_r <= 1'b0;
      op_s_r   <= ZERO_W;
      op_t_r   <= ZERO_W;
      mag_r    <= ZERO_W;
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
      count_r  <= {CNTW{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && is_iter_s) begin
            state_r  <= ST_LOAD;
            busy_r   <= 1'b1;
            is_div_r <= (bus.FS == FS_DIV);
            op_s_r   <= bus.S;
            op_t_r   <= bus.T;
          end else if (bus.start) begin
            y_hi_r <= ZERO_W;
            y_lo_r <= sc_lo_s;
            c_r    <= sc_c_s;
            v_r    <= sc_v_s;
            n_r    <= sc_lo_s[WIDTH-1];
            z_r    <= (sc_lo_s == ZERO_W);
            dz_r   <= 1'b0;
            done_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          hi_r    <= step_hi_s;
          lo_r    <= step_lo_s;
          mag_r   <= step_m_s;
          count_r <= CNT_INIT;
          state_r <= ST_ITER;
        end
        ST_ITER: begin
          hi_r    <= step_hi_s;
          lo_r    <= step_lo_s;
          count_r <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          y_hi_r  <= fix_hi_s;
          y_lo_r  <= fix_lo_s;
          c_r     <= 1'b0;
          v_r     <= fix_v_s;
          n_r     <= fix_n_s;
          z_r     <= (fix_hi_s == ZERO_W) && (fix_lo_s == ZERO_W);
          dz_r    <= fix_dz_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.Y_hi = y_hi_r;
  assign bus.Y_lo = y_lo_r;
  assign bus.C    = c_r;
  assign bus.V    = v_r;
  assign bus.N    = n_r;
  assign bus.Z    = z_r;
  assign bus.DZ   = dz_r;
endmodule

// File: tb/tb_alu_seq_n.sv
// Directed bench for alu_seq_n: WIDTH=32 and WIDTH=8 instances, hand-computed expectations.
module tb_alu_seq_n;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   dones;
  int   first_lat;

  alu_seq_n_if #(.WIDTH(32)) b32 ();
  alu_seq_n_if #(.WIDTH(8))  b8 ();

  alu_seq_n #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32));
  alu_seq_n #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(b8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {C,V,N,Z,DZ}
  function automatic logic [4:0] f32();
    return {b32.C, b32.V, b32.N, b32.Z, b32.DZ};
  endfunction

  function automatic logic [4:0] f8();
    return {b8.C, b8.V, b8.N, b8.Z, b8.DZ};
  endfunction

  task automatic op32(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                      output int l);
    @(negedge clk);
    b32.start = 1'b1; b32.FS = fs; b32.S = s; b32.T = t;
    @(negedge clk);
    b32.start = 1'b0;
    l = 1;
    while (b32.done !== 1'b1 && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic op8(input logic [4:0] fs, input logic [7:0] s, input logic [7:0] t,
                     output int l);
    @(negedge clk);
    b8.start = 1'b1; b8.FS = fs; b8.S = s; b8.T = t;
    @(negedge clk);
    b8.start = 1'b0;
    l = 1;
    while (b8.done !== 1'b1 && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    reset_n = 1'b1;
    b32.start = 1'b0; b32.FS = 5'h00; b32.S = 32'h0; b32.T = 32'h0;
    b8.start  = 1'b0; b8.FS  = 5'h00; b8.S  = 8'h0;  b8.T  = 8'h0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_status", {b32.busy, b32.done, f32()}, 64'h0);
    chk("reset_y", {b32.Y_hi, b32.Y_lo}, 64'h0);
    reset_n = 1'b1;

    op32(5'h02, 32'h7FFF_FFFF, 32'h1, lat);
    chk("add_ovf_lat", lat, 64'd1);
    chk("add_ovf_y", {b32.Y_hi, b32.Y_lo}, 64'h0000_0000_8000_0000);
    chk("add_ovf_flags", f32(), 5'b01100);

    op32(5'h1E, 32'hFFFF_FFFE, 32'h3, lat);
    chk("mul_lat", lat, 64'd34);
    chk("mul_y", {b32.Y_hi, b32.Y_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mul_flags", f32(), 5'b00100);

    op32(5'h1F, 32'hFFFF_FFF9, 32'h2, lat);
    chk("div_lat", lat, 64'd34);
    chk("div_y", {b32.Y_hi, b32.Y_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("div_flags", f32(), 5'b00100);

    op32(5'h1F, 32'h5, 32'h0, lat);
    chk("divz_lat", lat, 64'd34);
    chk("divz_y", {b32.Y_hi, b32.Y_lo}, 64'h0000_0005_FFFF_FFFF);
    chk("divz_flags", f32(), 5'b00101);

    op32(5'h1F, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_min_y", {b32.Y_hi, b32.Y_lo}, 64'h0000_0000_8000_0000);
    chk("div_min_flags", f32(), 5'b01100);

    op32(5'h04, 32'h3, 32'h5, lat);
    chk("sub_neg_y", b32.Y_lo, 64'hFFFF_FFFE);
    chk("sub_neg_flags", f32(), 5'b00100);
    op32(5'h04, 32'h5, 32'h3, lat);
    chk("sub_pos", {b32.Y_lo, 27'h0, f32()}, {32'h2, 27'h0, 5'b10000});
    op32(5'h03, 32'hFFFF_FFFF, 32'h1, lat);
    chk("addu_wrap", {b32.Y_lo, 27'h0, f32()}, {32'h0, 27'h0, 5'b10010});
    op32(5'h06, 32'hFFFF_FFFF, 32'h1, lat);
    chk("slt", {b32.Y_lo, 27'h0, f32()}, {32'h1, 27'h0, 5'b00000});
    op32(5'h07, 32'hFFFF_FFFF, 32'h1, lat);
    chk("sltu", {b32.Y_lo, 27'h0, f32()}, {32'h0, 27'h0, 5'b00010});
    op32(5'h0C, 32'h1, 32'd31, lat);
    chk("sll", b32.Y_lo, 64'h8000_0000);
    op32(5'h0D, 32'h8000_0000, 32'd4, lat);
    chk("srl", b32.Y_lo, 64'h0800_0000);
    op32(5'h0E, 32'h8000_0000, 32'd4, lat);
    chk("sra", {b32.Y_lo, 27'h0, f32()}, {32'hF800_0000, 27'h0, 5'b00100});
    op32(5'h0A, 32'hAAAA_5555, 32'hFFFF_0000, lat);
    chk("xor", b32.Y_lo, 64'h5555_5555);
    op32(5'h0B, 32'h0, 32'h0, lat);
    chk("nor", b32.Y_lo, 64'hFFFF_FFFF);
    op32(5'h01, 32'h1234_5678, 32'h9ABC_DEF0, lat);
    chk("pass_t", b32.Y_lo, 64'h9ABC_DEF0);
    op32(5'h0F, 32'h7FFF_FFFF, 32'h0, lat);
    chk("inc_ovf", {b32.Y_lo, 27'h0, f32()}, {32'h8000_0000, 27'h0, 5'b01100});
    op32(5'h10, 32'h0, 32'h0, lat);
    chk("dec_zero", {b32.Y_lo, 27'h0, f32()}, {32'hFFFF_FFFF, 27'h0, 5'b00100});
    op32(5'h10, 32'h8000_0000, 32'h0, lat);
    chk("dec_min", {b32.Y_lo, 27'h0, f32()}, {32'h7FFF_FFFF, 27'h0, 5'b11000});
    op32(5'h15, 32'h1, 32'h2, lat);
    chk("undef_fs", {b32.Y_hi, b32.Y_lo, 27'h0, f32()}, {64'h0, 27'h0, 5'b00010});

    // Back-to-back single-cycle ops with start held high.
    @(negedge clk);
    b32.start = 1'b1; b32.FS = 5'h02; b32.S = 32'h1; b32.T = 32'h2;
    @(negedge clk);
    chk("b2b_first", {b32.done, b32.Y_lo}, {1'b1, 32'h3});
    b32.FS = 5'h09; b32.S = 32'h4; b32.T = 32'h8;
    @(negedge clk);
    b32.start = 1'b0;
    chk("b2b_second", {b32.done, b32.Y_lo}, {1'b1, 32'hC});

    // MUL with start pulses during cycles 3..20 of the operation.
    @(negedge clk);
    b32.start = 1'b1; b32.FS = 5'h1E; b32.S = 32'h7; b32.T = 32'hFFFF_FFFB;
    dones = 0;
    first_lat = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (b32.done === 1'b1) begin
        dones++;
        if (first_lat == 0) first_lat = cyc;
      end
      b32.start = (cyc >= 2 && cyc <= 19);
      b32.FS = 5'h02; b32.S = 32'h1; b32.T = 32'h1;
    end
    b32.start = 1'b0;
    chk("busy_ign_dones", dones, 64'd1);
    chk("busy_ign_lat", first_lat, 64'd34);
    chk("busy_ign_y", {b32.Y_hi, b32.Y_lo}, 64'hFFFF_FFFF_FFFF_FFDD);

    // Reset in the middle of a DIV, then a fresh ADD.
    @(negedge clk);
    b32.start = 1'b1; b32.FS = 5'h1F; b32.S = 32'd100; b32.T = 32'd7;
    @(negedge clk);
    b32.start = 1'b0;
    chk("mid_busy", b32.busy, 64'd1);
    repeat (21) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_status", {b32.busy, b32.done, f32()}, 64'h0);
    chk("mid_rst_y", {b32.Y_hi, b32.Y_lo}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    op32(5'h02, 32'h1, 32'h1, lat);
    chk("post_rst_add", {b32.Y_lo, 32'(lat)}, {32'h2, 32'h1});

    // WIDTH=8 instance.
    op8(5'h1E, 8'h80, 8'h80, lat);
    chk("w8_mul_lat", lat, 64'd10);
    chk("w8_mul_y", {b8.Y_hi, b8.Y_lo, 3'h0, f8()}, {8'h40, 8'h00, 3'h0, 5'b00000});
    op8(5'h1E, 8'h7F, 8'h81, lat);
    chk("w8_mul_neg", {b8.Y_hi, b8.Y_lo, 3'h0, f8()}, {8'hC0, 8'hFF, 3'h0, 5'b00100});
    op8(5'h1F, 8'h80, 8'h03, lat);
    chk("w8_div", {b8.Y_hi, b8.Y_lo, 3'h0, f8()}, {8'hFE, 8'hD6, 3'h0, 5'b00100});
    op8(5'h05, 8'h00, 8'h01, lat);
    chk("w8_subu", {b8.Y_lo, 3'h0, f8(), 32'(lat)}, {8'hFF, 3'h0, 5'b00100, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
